reg_access_arbiter: RTL and testbench
=====================================

REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requester ports (fixed at 2 in this revision).
REQ-002 clk_i  input  1  single clock, rising-edge.
REQ-003 rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 req_i  input  [NREQ-1:0]  per-requester access request; held high until the matching gnt_o bit is seen.
REQ-005 we_i  input  [NREQ-1:0]  per-requester write enable (1 write, 0 read).
REQ-006 addr_i  input  [NREQ*3-1:0]  per-requester register address, 3 bits each.
REQ-007 wdata_i  input  [NREQ*16-1:0]  per-requester write data, 16 bits each.
REQ-008 gnt_o  output  [NREQ-1:0]  one-cycle grant pulse; the request is latched on this cycle.
REQ-009 done_o  output  [NREQ-1:0]  one-cycle completion pulse to the granted requester.
REQ-010 err_o  output  1  qualifies done_o: access was to a read-only or unmapped address.
REQ-011 rdata_o  output  16  read data, valid while done_o is high, else 0.
REQ-012 acc_en_o  output  1  register-block access enable.
REQ-013 wr_en_o  output  1  register-block write enable.
REQ-014 addr_o  output  3  register-block address.
REQ-015 wdata_o  output  16  register-block write data.
REQ-016 rdata_i  input  16  register-block combinational read data.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, CMD_CLR, RESP.
REQ-018 IDLE: if any req_i bit is high, select a winner, latch its we/addr/wdata, and go to ISSUE; gnt_o SHALL pulse on the ISSUE cycle.
REQ-019 Arbitration SHALL be round-robin: if both request, the one not granted last wins; single request wins regardless; the last-grant pointer resets to 1 so requester 0 wins first.
REQ-020 ISSUE: acc_en_o=1, wr_en_o/addr_o/wdata_o from the latched request; for reads rdata_i SHALL be registered at the end of this cycle.
REQ-021 Writable addresses: 0,1,2,3,5; read-only: 4,6; unmapped: 7; reads are legal at 0-6.
REQ-022 A write to 4, 6 or 7, or a read of 7, SHALL keep acc_en_o low in ISSUE, set err_o in RESP, and return rdata_o=0.
REQ-023 A legal write to address 5 (COMMAND) with wdata[4] or wdata[0] set SHALL go ISSUE->CMD_CLR, which drives acc_en_o=1, wr_en_o=1, addr_o=5, wdata_o=0 for exactly one cycle, then RESP; otherwise ISSUE->RESP.
REQ-024 RESP: done_o pulses for the granted requester; rdata_o holds the captured read data (0 for writes); next state IDLE.
REQ-025 Each transaction SHALL take 3 cycles from request sample to done (4 with CMD_CLR); the minimum spacing between grants is 3 cycles.
REQ-026 Outside ISSUE and CMD_CLR, acc_en_o, wr_en_o, addr_o and wdata_o SHALL be 0.
REQ-027 req_i changes outside IDLE SHALL be ignored; a req_i still high in RESP is arbitrated as a new request in the following IDLE.
REQ-028 At most one bit of gnt_o and of done_o SHALL ever be high.

Reset
REQ-029 Reset SHALL force state IDLE, last-grant pointer 1, and all outputs and latched request fields to 0.
REQ-030 Reset mid-transaction SHALL abort it with no done_o and no CMD_CLR write; the register block is reset by the same rstn_i.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the register address constants (CTRL0=0, PWM_MODE=1, CNT_TIMER_MODE0=2, CNT_TIMER_MODE1=3, ACT_CNT_VALUE=4, COMMAND=5, CAPTURE_STATUS=6).
REQ-032 The round-robin selector SHALL be one sub-module, rr_arbiter2 (inputs req and last-grant pointer; output one-hot winner).

Verification
REQ-033 Req0 write addr 1 data 0x2155 -> gnt0 on cycle 1, acc_en/wr_en with addr 1 on cycle 1, done0 on cycle 2 with err 0; a later read of addr 1 returns 0x2155.
REQ-034 Req0 and req1 both held high for reads of addr 0 -> grants alternate 0,1,0,1 with grants 3 cycles apart.
REQ-035 Req1 write addr 5 data 0x0011 -> ISSUE writes 0x0011, CMD_CLR writes 0x0000 to addr 5, done1 on the 4th cycle; a later read of addr 5 returns 0.
REQ-036 Req0 write addr 4 data 0xFFFF -> acc_en_o stays 0, done0 with err_o=1 and rdata_o=0; a read of addr 4 returns the counter value with err_o=0.
REQ-037 rstn_i low during CMD_CLR -> all outputs 0 immediately, no done pulse; after release with req0 and req1 both high, requester 0 is granted first.

Source files
------------

// File: rtl/reg_access_arbiter_pkg.sv
// Shared types and register map for the register access arbiter.
// Holds FSM state encoding, address constants and access legality check.
package reg_access_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CMD_CLR = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [2:0] CTRL0           = 3'd0;
    localparam logic [2:0] PWM_MODE        = 3'd1;
    localparam logic [2:0] CNT_TIMER_MODE0 = 3'd2;
    localparam logic [2:0] CNT_TIMER_MODE1 = 3'd3;
    localparam logic [2:0] ACT_CNT_VALUE   = 3'd4;
    localparam logic [2:0] COMMAND         = 3'd5;
    localparam logic [2:0] CAPTURE_STATUS  = 3'd6;
    localparam logic [2:0] UNMAPPED        = 3'd7;

    // Writes to read-only/unmapped slots and reads of the hole are errors.
    function automatic logic access_err(input logic we, input logic [2:0] a);
        if (we)
            access_err = (a == ACT_CNT_VALUE) || (a == CAPTURE_STATUS) ||
                         (a == UNMAPPED);
        else
            access_err = (a == UNMAPPED);
    endfunction

endpackage

// File: rtl/reg_access_arbiter_rr_arbiter2.sv
// Two-way round-robin selector.
// Last-grant pointer names the requester served most recently.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Contention goes to the requester not served last.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11)
            gnt = last ? 2'b01 : 2'b10;
        else
            gnt = req;
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Arbitrates two requesters onto a single register-block port.
// One access per grant; COMMAND self-clear inserts an extra write.
module reg_access_arbiter
    import reg_access_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ-1:0]   we_i,
    input  logic [NREQ*3-1:0] addr_i,
    input  logic [NREQ*16-1:0] wdata_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   done_o,
    output logic              err_o,
    output logic [15:0]       rdata_o,
    output logic              acc_en_o,
    output logic              wr_en_o,
    output logic [2:0]        addr_o,
    output logic [15:0]       wdata_o,
    input  logic [15:0]       rdata_i
);

    state_t          r_state;
    logic            r_last;
    logic [1:0]      r_gnt;
    logic            r_we;
    logic [2:0]      r_addr;
    logic [15:0]     r_wdata;
    logic            r_err;
    logic [15:0]     r_rdata;

    logic [1:0]      w_win;
    logic            w_sel;
    logic            w_we;
    logic [2:0]      w_addr;
    logic [15:0]     w_wdata;
    logic            w_cmd;

    rr_arbiter2 u_rr (
        .req  (req_i[1:0]),
        .last (r_last),
        .gnt  (w_win)
    );

    // Route the winning requester's fields to the latch inputs.
    always_comb begin
        w_sel   = w_win[1];
        w_we    = w_sel ? we_i[1]         : we_i[0];
        w_addr  = w_sel ? addr_i[5:3]     : addr_i[2:0];
        w_wdata = w_sel ? wdata_i[31:16]  : wdata_i[15:0];
        w_cmd   = r_we && !r_err && (r_addr == COMMAND) &&
                  (r_wdata[4] || r_wdata[0]);
    end

    // Transaction FSM with request latch and read-data capture.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_we    <= 1'b0;
            r_addr  <= 3'd0;
            r_wdata <= 16'd0;
            r_err   <= 1'b0;
            r_rdata <= 16'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (|req_i[1:0]) begin
                        r_gnt   <= w_win;
                        r_last  <= w_sel;
                        r_we    <= w_we;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_err   <= access_err(w_we, w_addr);
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_rdata <= (!r_we && !r_err) ? rdata_i : 16'd0;
                    r_state <= w_cmd ? CMD_CLR : RESP;
                end
                CMD_CLR: r_state <= RESP;
                RESP:    r_state <= IDLE;
            endcase
        end
    end

    // Output decode; everything is quiet outside its owning state.
    always_comb begin
        gnt_o    = '0;
        done_o   = '0;
        err_o    = 1'b0;
        rdata_o  = 16'd0;
        acc_en_o = 1'b0;
        wr_en_o  = 1'b0;
        addr_o   = 3'd0;
        wdata_o  = 16'd0;
        unique case (r_state)
            ISSUE: begin
                gnt_o    = r_gnt;
                acc_en_o = !r_err;
                wr_en_o  = r_we && !r_err;
                addr_o   = r_addr;
                wdata_o  = r_wdata;
            end
            CMD_CLR: begin
                acc_en_o = 1'b1;
                wr_en_o  = 1'b1;
                addr_o   = COMMAND;
            end
            RESP: begin
                done_o  = r_gnt;
                err_o   = r_err;
                rdata_o = r_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a small register-block model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_reg_access_arbiter;

    localparam logic [15:0] CNT_VAL = 16'h0ABC;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic [15:0] rdata;
    logic        acc_en;
    logic        wr_en;
    logic [2:0]  addr_o;
    logic [15:0] wdata_o;
    logic [15:0] rdata_i;
    logic [15:0] regs [0:7];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_access_arbiter #(.NREQ(2)) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .gnt_o    (gnt),
        .done_o   (done),
        .err_o    (err),
        .rdata_o  (rdata),
        .acc_en_o (acc_en),
        .wr_en_o  (wr_en),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .rdata_i  (rdata_i)
    );

    // Register block: plain storage, address 4 reads a fixed counter.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
        end else if (acc_en && wr_en) begin
            regs[addr_o] <= wdata_o;
        end
    end

    always_comb rdata_i = (addr_o == 3'd4) ? CNT_VAL : regs[addr_o];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w,
                         input logic [2:0] a1, input logic [2:0] a0,
                         input logic [15:0] d1, input logic [15:0] d0);
        req   = r;
        we    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] eg;
        logic [1:0] ed;
        rstn = 1'b0;
        drive(2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
        repeat (2) tick();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_acc", acc_en, 1'b0);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_err", err, 1'b0);
        rstn = 1'b1;

        // both requesters reading addr 0, grants alternate starting at 0
        drive(2'b11, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            eg = 2'b00;
            ed = 2'b00;
            if (k % 3 == 1) eg = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
            if (k % 3 == 2) ed = (((k - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
            chk("rr_gnt", gnt, eg);
            chk("rr_done", done, ed);
            if (k == 10) req = 2'b00;
        end

        // req0 write addr 1 then read it back
        drive(2'b01, 2'b01, 3'd0, 3'd1, 16'h0, 16'h2155);
        tick();
        chk("w1_gnt", gnt, 2'b01);
        chk("w1_acc", acc_en, 1'b1);
        chk("w1_wr", wr_en, 1'b1);
        chk("w1_addr", addr_o, 3'd1);
        chk("w1_wdata", wdata_o, 16'h2155);
        req = 2'b00;
        tick();
        chk("w1_done", done, 2'b01);
        chk("w1_err", err, 1'b0);
        chk("w1_acc_off", acc_en, 1'b0);
        tick();
        drive(2'b01, 2'b00, 3'd0, 3'd1, 16'h0, 16'h0);
        tick();
        chk("r1_wr", wr_en, 1'b0);
        req = 2'b00;
        tick();
        chk("r1_done", done, 2'b01);
        chk("r1_rdata", rdata, 16'h2155);
        tick();

        // req1 COMMAND write with self-clear
        drive(2'b10, 2'b10, 3'd5, 3'd0, 16'h0011, 16'h0);
        tick();
        chk("c_gnt", gnt, 2'b10);
        chk("c_addr", addr_o, 3'd5);
        chk("c_wdata", wdata_o, 16'h0011);
        req = 2'b00;
        tick();
        chk("clr_acc", acc_en, 1'b1);
        chk("clr_wr", wr_en, 1'b1);
        chk("clr_addr", addr_o, 3'd5);
        chk("clr_wdata", wdata_o, 16'h0);
        chk("clr_done", done, 2'b00);
        tick();
        chk("c_done", done, 2'b10);
        tick();
        drive(2'b10, 2'b00, 3'd5, 3'd0, 16'h0, 16'h0);
        tick();
        req = 2'b00;
        tick();
        chk("rc_done", done, 2'b10);
        chk("rc_rdata", rdata, 16'h0);
        tick();

        // COMMAND write without trigger bits takes the short path
        drive(2'b01, 2'b01, 3'd0, 3'd5, 16'h0, 16'h0002);
        tick();
        req = 2'b00;
        tick();
        chk("c2_done", done, 2'b01);
        tick();

        // write to read-only counter is rejected
        drive(2'b01, 2'b01, 3'd0, 3'd4, 16'h0, 16'hFFFF);
        tick();
        chk("ro_acc", acc_en, 1'b0);
        req = 2'b00;
        tick();
        chk("ro_done", done, 2'b01);
        chk("ro_err", err, 1'b1);
        chk("ro_rdata", rdata, 16'h0);
        tick();
        drive(2'b01, 2'b00, 3'd0, 3'd4, 16'h0, 16'h0);
        tick();
        chk("rcnt_acc", acc_en, 1'b1);
        req = 2'b00;
        tick();
        chk("rcnt_err", err, 1'b0);
        chk("rcnt_rdata", rdata, CNT_VAL);
        tick();

        // read of the unmapped slot
        drive(2'b01, 2'b00, 3'd0, 3'd7, 16'h0, 16'h0);
        tick();
        chk("r7_acc", acc_en, 1'b0);
        req = 2'b00;
        tick();
        chk("r7_err", err, 1'b1);
        chk("r7_rdata", rdata, 16'h0);
        tick();

        // reset during CMD_CLR aborts, then requester 0 wins first
        drive(2'b10, 2'b10, 3'd5, 3'd0, 16'h0001, 16'h0);
        tick();
        req = 2'b00;
        tick();
        chk("ab_clr_acc", acc_en, 1'b1);
        rstn = 1'b0;
        #1;
        chk("ab_acc", acc_en, 1'b0);
        chk("ab_wr", wr_en, 1'b0);
        chk("ab_addr", addr_o, 3'd0);
        chk("ab_done", done, 2'b00);
        tick();
        chk("ab_done2", done, 2'b00);
        drive(2'b11, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
        rstn = 1'b1;
        tick();
        chk("ab_gnt", gnt, 2'b01);
        req = 2'b00;
        tick();
        chk("ab_done3", done, 2'b01);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
